// File: rtl/j204c_link_bringup_ctrl_if.sv
// JESD204C link bring-up control/status bundle.
// master drives the requests and PMA/lock status, slave is the controller.
interface j204c_link_bringup_ctrl_if;
    logic       start;
    logic       stop;
    logic [3:0] tx_pma_ready;
    logic [3:0] rx_pma_ready;
    logic       rx_sh_lock;
    logic       rx_emb_lock;
    logic [3:0] rx_crc_err;
    logic       link_rst;
    logic       sysref_req;
    logic       link_up;
    logic       busy;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] crc_err_cnt;

    modport master (
        output start, stop, tx_pma_ready, rx_pma_ready,
        output rx_sh_lock, rx_emb_lock, rx_crc_err,
        input  link_rst, sysref_req, link_up, busy, fail,
        input  state, retry_cnt, crc_err_cnt
    );

    modport slave (
        input  start, stop, tx_pma_ready, rx_pma_ready,
        input  rx_sh_lock, rx_emb_lock, rx_crc_err,
        output link_rst, sysref_req, link_up, busy, fail,
        output state, retry_cnt, crc_err_cnt
    );
endinterface

// File: rtl/j204c_link_bringup_ctrl.sv
// JESD204C link bring-up sequencer: reset, PMA wait, SYSREF, lock wait,
// retry/fail handling and in-link CRC error counting.
module j204c_link_bringup_ctrl #(
    parameter int RST_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535,
    parameter int SYSREF_CYC  = 4,
    parameter int LOCK_HOLD   = 8,
    parameter int MAX_RETRY   = 3
) (
    input logic                        mgmt_clk,
    input logic                        mgmt_reset,
    j204c_link_bringup_ctrl_if.slave   bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET     = 3'd1;
    localparam logic [2:0] S_WAIT_PMA  = 3'd2;
    localparam logic [2:0] S_SYSREF    = 3'd3;
    localparam logic [2:0] S_WAIT_LOCK = 3'd4;
    localparam logic [2:0] S_LINK_UP   = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] SR_LAST  = 16'(SYSREF_CYC - 1);
    localparam logic [7:0]  HOLD_MAX = 8'(LOCK_HOLD);
    localparam logic [1:0]  RETRY_MX = 2'(MAX_RETRY);

    logic [2:0]  st_q, st_nx;
    logic [15:0] cyc_q, cyc_nx;
    logic [7:0]  hold_q, hold_nx;
    logic [1:0]  retry_q, retry_nx;
    logic [7:0]  crc_q, crc_nx;

    logic link_rst_q, sysref_q, link_up_q, busy_q, fail_q;

    logic       lock;
    logic       pma_ok;
    logic       timeout;
    logic [2:0] pop;
    logic [8:0] crc_sum;

    assign lock    = bus.rx_sh_lock & bus.rx_emb_lock;
    assign pma_ok  = (bus.tx_pma_ready == 4'hF) &&
                     (bus.rx_pma_ready == 4'hF);
    assign timeout = (cyc_q == TO_LAST);
    assign pop     = {2'b0, bus.rx_crc_err[0]} +
                     {2'b0, bus.rx_crc_err[1]} +
                     {2'b0, bus.rx_crc_err[2]} +
                     {2'b0, bus.rx_crc_err[3]};
    assign crc_sum = {1'b0, crc_q} + {6'b0, pop};

    always_comb begin
        st_nx    = st_q;
        retry_nx = retry_q;
        hold_nx  = 8'd0;
        crc_nx   = crc_q;
        unique case (1'b1)
            (st_q == S_IDLE): begin
                if (bus.start) begin
                    st_nx    = S_RESET;
                    retry_nx = 2'd0;
                end
            end
            (st_q == S_RESET): begin
                if (cyc_q == RST_LAST)
                    st_nx = S_WAIT_PMA;
            end
            (st_q == S_WAIT_PMA): begin
                if (pma_ok) begin
                    st_nx = S_SYSREF;
                end else if (timeout) begin
                    if (retry_q < RETRY_MX) begin
                        st_nx    = S_RESET;
                        retry_nx = retry_q + 2'd1;
                    end else begin
                        st_nx = S_FAIL;
                    end
                end
            end
            (st_q == S_SYSREF): begin
                if (cyc_q == SR_LAST)
                    st_nx = S_WAIT_LOCK;
            end
            (st_q == S_WAIT_LOCK): begin
                hold_nx = lock ? hold_q + 8'd1 : 8'd0;
                // Reaching the hold target beats a coincident timeout.
                if (hold_nx == HOLD_MAX) begin
                    st_nx   = S_LINK_UP;
                    hold_nx = 8'd0;
                    crc_nx  = 8'd0;
                end else if (timeout) begin
                    hold_nx = 8'd0;
                    if (retry_q < RETRY_MX) begin
                        st_nx    = S_RESET;
                        retry_nx = retry_q + 2'd1;
                    end else begin
                        st_nx = S_FAIL;
                    end
                end
            end
            (st_q == S_LINK_UP): begin
                crc_nx = crc_sum[8] ? 8'hFF : crc_sum[7:0];
                if (!lock) begin
                    st_nx    = S_RESET;
                    retry_nx = 2'd0;
                end
            end
            (st_q == S_FAIL): begin
                if (bus.start) begin
                    st_nx    = S_RESET;
                    retry_nx = 2'd0;
                end
            end
            default: st_nx = S_IDLE;
        endcase
        // Abort outranks everything; the CRC tally is kept for post-mortem.
        if (bus.stop) begin
            st_nx    = S_IDLE;
            retry_nx = 2'd0;
            hold_nx  = 8'd0;
            crc_nx   = crc_q;
        end
    end

    always_comb begin
        if (bus.stop || (st_nx != st_q))
            cyc_nx = 16'd0;
        else if (cyc_q == 16'hFFFF)
            cyc_nx = cyc_q;
        else
            cyc_nx = cyc_q + 16'd1;
    end

    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) begin
            st_q       <= S_IDLE;
            cyc_q      <= 16'd0;
            hold_q     <= 8'd0;
            retry_q    <= 2'd0;
            crc_q      <= 8'd0;
            link_rst_q <= 1'b1;
            sysref_q   <= 1'b0;
            link_up_q  <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            st_q       <= st_nx;
            cyc_q      <= cyc_nx;
            hold_q     <= hold_nx;
            retry_q    <= retry_nx;
            crc_q      <= crc_nx;
            link_rst_q <= (st_nx == S_IDLE) || (st_nx == S_RESET) ||
                          (st_nx == S_FAIL);
            sysref_q   <= (st_nx == S_SYSREF);
            link_up_q  <= (st_nx == S_LINK_UP);
            busy_q     <= (st_nx == S_RESET) || (st_nx == S_WAIT_PMA) ||
                          (st_nx == S_SYSREF) || (st_nx == S_WAIT_LOCK);
            fail_q     <= (st_nx == S_FAIL);
        end
    end

    assign bus.state       = st_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.crc_err_cnt = crc_q;
    assign bus.link_rst    = link_rst_q;
    assign bus.sysref_req  = sysref_q;
    assign bus.link_up     = link_up_q;
    assign bus.busy        = busy_q;
    assign bus.fail        = fail_q;

endmodule

// File: tb/tb_j204c_link_bringup_ctrl.sv
// Scoreboarded bench for j204c_link_bringup_ctrl: directed bring-up
// scenarios plus a randomized soak against a behavioural model.
module tb_j204c_link_bringup_ctrl;

    localparam int RST  = 16;
    localparam int TO   = 1000;
    localparam int SRC  = 4;
    localparam int LH   = 8;
    localparam int MR   = 3;

    typedef struct packed {
        logic [2:0] st;
        logic       lr;
        logic       sr;
        logic       lu;
        logic       bz;
        logic       fl;
        logic [1:0] rt;
        logic [7:0] cc;
    } obs_t;

    logic mgmt_clk = 1'b0;
    logic mgmt_reset;

    j204c_link_bringup_ctrl_if bus ();

    j204c_link_bringup_ctrl #(
        .RST_CYC    (RST),
        .TIMEOUT_CYC(TO),
        .SYSREF_CYC (SRC),
        .LOCK_HOLD  (LH),
        .MAX_RETRY  (MR)
    ) dut (
        .mgmt_clk  (mgmt_clk),
        .mgmt_reset(mgmt_reset),
        .bus       (bus)
    );

    always #5 mgmt_clk = ~mgmt_clk;

    int total = 0;
    int bad   = 0;
    obs_t sb[$];

    // Model: phase name, cycles spent in phase, locked run length, retries.
    int ph    = 0;
    int dwell = 0;
    int run   = 0;
    int tries = 0;
    int errs  = 0;

    function automatic obs_t expect_of();
        obs_t e;
        e.st = 3'(ph);
        e.lr = (ph == 0) || (ph == 1) || (ph == 6);
        e.sr = (ph == 3);
        e.lu = (ph == 5);
        e.bz = (ph >= 1) && (ph <= 4);
        e.fl = (ph == 6);
        e.rt = 2'(tries);
        e.cc = 8'(errs);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.st = bus.state;
        a.lr = bus.link_rst;
        a.sr = bus.sysref_req;
        a.lu = bus.link_up;
        a.bz = bus.busy;
        a.fl = bus.fail;
        a.rt = bus.retry_cnt;
        a.cc = bus.crc_err_cnt;
        return a;
    endfunction

    task automatic give_up_or_retry(output int nxt);
        if (tries < MR) begin
            tries++;
            nxt = 1;
        end else begin
            nxt = 6;
        end
    endtask

    task automatic model_step();
        int nxt;
        bit locked;
        locked = bus.rx_sh_lock && bus.rx_emb_lock;
        nxt = ph;
        if (mgmt_reset) begin
            ph = 0; dwell = 0; run = 0; tries = 0; errs = 0;
            return;
        end
        if (bus.stop) begin
            ph = 0; dwell = 0; run = 0; tries = 0;
            return;
        end
        case (ph)
            0, 6: if (bus.start) begin nxt = 1; tries = 0; end
            1: if (dwell + 1 == RST) nxt = 2;
            2: begin
                if (bus.tx_pma_ready == 4'hF && bus.rx_pma_ready == 4'hF)
                    nxt = 3;
                else if (dwell + 1 == TO)
                    give_up_or_retry(nxt);
            end
            3: if (dwell + 1 == SRC) nxt = 4;
            4: begin
                run = locked ? run + 1 : 0;
                if (run == LH) begin
                    nxt = 5;
                    errs = 0;
                end else if (dwell + 1 == TO) begin
                    give_up_or_retry(nxt);
                end
            end
            5: begin
                errs = errs + $countones(bus.rx_crc_err);
                if (errs > 255) errs = 255;
                if (!locked) begin nxt = 1; tries = 0; end
            end
            default: nxt = 0;
        endcase
        if (nxt != ph) begin
            dwell = 0;
            run = 0;
        end else begin
            dwell++;
        end
        ph = nxt;
    endtask

    task automatic tick();
        model_step();
        sb.push_back(expect_of());
        @(posedge mgmt_clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge mgmt_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = sample();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got st=%0d lr=%b sr=%b lu=%b bz=%b fl=%b rt=%0d cc=%0d want st=%0d lr=%b sr=%b lu=%b bz=%b fl=%b rt=%0d cc=%0d",
                        $time, a.st, a.lr, a.sr, a.lu, a.bz, a.fl, a.rt,
                        a.cc, e.st, e.lr, e.sr, e.lu, e.bz, e.fl, e.rt,
                        e.cc);
                end
            end
        end
    end

    initial begin : stim
        obs_t rv, a;
        int n;
        rv = '{st: 3'd0, lr: 1'b1, sr: 1'b0, lu: 1'b0, bz: 1'b0,
               fl: 1'b0, rt: 2'd0, cc: 8'd0};
        mgmt_reset       = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.tx_pma_ready = 4'h0;
        bus.rx_pma_ready = 4'h0;
        bus.rx_sh_lock   = 1'b1;
        bus.rx_emb_lock  = 1'b1;
        bus.rx_crc_err   = 4'h0;
        ticks(2);
        mgmt_reset = 1'b0;
        ticks(3);

        // Nominal bring-up with PMA ready 5 cycles after RESET exit.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; ticks(RST + 5);
        bus.tx_pma_ready = 4'hF;
        bus.rx_pma_ready = 4'hF;
        ticks(SRC + LH + 4);
        for (int i = 0; i < 10; i++) begin
            bus.rx_crc_err = 4'($urandom);
            tick();
        end
        bus.rx_crc_err = 4'hF; ticks(70);
        bus.rx_crc_err = 4'h0; ticks(2);
        bus.rx_sh_lock = 1'b0; tick();
        bus.rx_sh_lock = 1'b1; ticks(2);

        // PMA stuck: four timeouts then FAIL, restart from FAIL.
        bus.rx_pma_ready = 4'h7;
        ticks(4 * (RST + TO) + 20);
        bus.start = 1'b1; tick();
        bus.start = 1'b0; ticks(3);
        bus.stop = 1'b1; tick();
        bus.stop = 1'b0;
        bus.rx_pma_ready = 4'hF;
        ticks(2);

        // Lock glitch after 5 locked cycles in WAIT_LOCK.
        bus.rx_sh_lock = 1'b0;
        bus.rx_emb_lock = 1'b0;
        bus.start = 1'b1; tick();
        bus.start = 1'b0; ticks(RST + 1 + SRC + 2);
        bus.rx_sh_lock = 1'b1;
        bus.rx_emb_lock = 1'b1;
        ticks(5);
        bus.rx_emb_lock = 1'b0; tick();
        bus.rx_emb_lock = 1'b1; ticks(12);

        // Stop and start together while waiting for lock.
        bus.rx_sh_lock = 1'b0; tick();
        ticks(RST + 1 + SRC + 3);
        bus.start = 1'b1; bus.stop = 1'b1; tick();
        bus.start = 1'b0; bus.stop = 1'b0; ticks(3);

        // Async reset in the second SYSREF cycle.
        bus.rx_sh_lock = 1'b1;
        bus.start = 1'b1; tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.state != 3'd3 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (bus.state != 3'd3) begin
            bad++;
            $display("FAIL sysref_wait got st=%0d want 3", bus.state);
        end
        tick();
        mgmt_reset = 1'b1;
        #1;
        a = sample();
        total++;
        if (a !== rv) begin
            bad++;
            $display("FAIL async_reset got %h want %h", a, rv);
        end
        tick();
        mgmt_reset = 1'b0;
        ticks(5);

        // Randomized soak.
        for (int i = 0; i < 4000; i++) begin
            bus.start        = ($urandom % 40) == 0;
            bus.stop         = ($urandom % 300) == 0;
            bus.tx_pma_ready = ($urandom % 4) == 0 ? 4'($urandom) : 4'hF;
            bus.rx_pma_ready = ($urandom % 4) == 0 ? 4'($urandom) : 4'hF;
            bus.rx_sh_lock   = ($urandom % 60) != 0;
            bus.rx_emb_lock  = ($urandom % 60) != 0;
            bus.rx_crc_err   = ($urandom % 8) == 0 ? 4'($urandom) : 4'h0;
            tick();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        ticks(2);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j204c_link_bringup_ctrl.md
J204C_LINK_BRINGUP_CTRL -- requirements
Module: j204c_link_bringup_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 16: cycles link_rst is held in RESET (range 1..65535).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: WAIT_PMA/WAIT_LOCK timeout in cycles (range 1..65535).
REQ-003 SHALL have parameter SYSREF_CYC, default 4: sysref_req pulse width in cycles (range 1..255).
REQ-004 SHALL have parameter LOCK_HOLD, default 8: consecutive locked cycles needed to declare link up (range 1..255).
REQ-005 SHALL have parameter MAX_RETRY, default 3: retries before FAIL (range 0..3).
REQ-006 SHALL have port mgmt_clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port mgmt_reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports start in 1 (bring-up request pulse) and stop in 1 (abort to IDLE).
REQ-009 SHALL have ports tx_pma_ready in 4 and rx_pma_ready in 4 (per-lane PMA ready).
REQ-010 SHALL have ports rx_sh_lock in 1, rx_emb_lock in 1 and rx_crc_err in 4 (per-lane CRC error strobe).
REQ-011 SHALL have ports link_rst out 1 (link reset request to reset sequencer) and sysref_req out 1 (SYSREF request to TX and RX).
REQ-012 SHALL have ports link_up out 1, busy out 1, fail out 1, state out 3, retry_cnt out 2 and crc_err_cnt out 8.
REQ-013 SHALL treat all inputs as already synchronous to mgmt_clk; no internal synchronizers.

Function
REQ-014 SHALL implement FSM, encoded on state: IDLE=0, RESET=1, WAIT_PMA=2, SYSREF=3, WAIT_LOCK=4, LINK_UP=5, FAIL=6.
REQ-015 SHALL use a 16-bit cycle counter cleared on every state transition and incremented otherwise, saturating at 65535.
REQ-016 IDLE: start=1 -> RESET, with retry_cnt cleared to 0.
REQ-017 RESET: link_rst=1; after RST_CYC cycles in RESET -> WAIT_PMA.
REQ-018 WAIT_PMA: when tx_pma_ready==4'hF and rx_pma_ready==4'hF -> SYSREF; else on TIMEOUT_CYC cycles in state -> retry (REQ-022).
REQ-019 SYSREF: sysref_req=1 for exactly SYSREF_CYC cycles, then -> WAIT_LOCK; sysref_req=0 in all other states.
REQ-020 WAIT_LOCK: lock-hold counter counts cycles with rx_sh_lock&rx_emb_lock=1 and is cleared on any cycle where either is 0. At LOCK_HOLD -> LINK_UP. On TIMEOUT_CYC cycles in state -> retry. If both conditions hit in the same cycle, LINK_UP wins.
REQ-021 LINK_UP: link_up=1. If rx_sh_lock=0 or rx_emb_lock=0 in any cycle -> RESET, with retry_cnt cleared to 0.
REQ-022 Retry: if retry_cnt < MAX_RETRY, increment retry_cnt and go to RESET; otherwise go to FAIL with retry_cnt unchanged.
REQ-023 FAIL: fail=1 and link_rst=1. start=1 -> RESET, with retry_cnt cleared to 0.
REQ-024 link_rst SHALL be 1 in IDLE, RESET and FAIL, and 0 otherwise.
REQ-025 busy SHALL be 1 in RESET, WAIT_PMA, SYSREF and WAIT_LOCK.
REQ-026 stop=1 SHALL force IDLE on the next edge from any state, with priority over start, timeout and lock events. Counters SHALL clear; crc_err_cnt SHALL hold.
REQ-027 start SHALL be ignored in RESET, WAIT_PMA, SYSREF, WAIT_LOCK and LINK_UP.
REQ-028 crc_err_cnt SHALL clear to 0 on the WAIT_LOCK->LINK_UP transition. While in LINK_UP it SHALL add popcount(rx_crc_err) (0..4) each cycle, saturating at 255 with no wrap.
REQ-029 All outputs SHALL be registered; a state change SHALL be visible on outputs in the cycle after the triggering input.

Reset
REQ-030 On mgmt_reset=1, immediately and asynchronously: state=IDLE, link_rst=1, sysref_req=0, link_up=0, busy=0, fail=0, retry_cnt=0, crc_err_cnt=0, all internal counters=0.
REQ-031 Reset asserted mid-operation, including during a SYSREF pulse, SHALL truncate the pulse with no glitch on sysref_req. Operation resumes only via a new start after reset release.

Verification (RST_CYC=16, TIMEOUT_CYC=1000, SYSREF_CYC=4, LOCK_HOLD=8, MAX_RETRY=3)
REQ-032 Nominal bring-up: start pulse, PMA ready 4'hF 5 cycles after RESET exit, locks high -> link_rst high 16 cycles, sysref_req high exactly 4 cycles, link_up=1 after 8 locked cycles, retry_cnt=0.
REQ-033 PMA timeout: rx_pma_ready stuck 4'h7 -> 4 timeouts of 1000 cycles each, retry_cnt steps 1,2,3, then state=6, fail=1, link_rst=1; a later start gives state=1 and retry_cnt=0.
REQ-034 Lock glitch: emb_lock drops for 1 cycle after 5 locked cycles in WAIT_LOCK -> hold counter restarts; link_up asserts only after 8 further consecutive locked cycles.
REQ-035 Lock loss and CRC counting: in LINK_UP, rx_crc_err=4'hF for 70 cycles -> crc_err_cnt=255 (saturated); then sh_lock=0 -> RESET with link_up=0 and retry_cnt=0.
REQ-036 Stop and reset precedence: stop and start together in WAIT_LOCK -> IDLE next cycle. mgmt_reset asserted in cycle 2 of SYSREF -> sysref_req=0 immediately and all outputs at REQ-030 values.
